// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates nickel/dime/quarter credit toward PRICE_UNITS,
// vends for one cycle, then pays change (or a cancel refund) as one nickel pulse per cycle.
module vending_machine_param #(
  parameter int PRICE_UNITS = 4,
  parameter int CREDIT_W    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickle,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                soda,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sales_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE_UNITS);
  localparam logic [CREDIT_W:0]   VAL_NICK  = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0]   VAL_DIME  = (CREDIT_W+1)'(2);
  localparam logic [CREDIT_W:0]   VAL_QTR   = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] CREDIT_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_next_credit;
  logic [CNT_W-1:0]    r_sales;
  logic [CNT_W-1:0]    w_next_sales;
  logic                r_soda;
  logic                r_change;
  logic                r_busy;
  logic                r_coin_reject;
  logic                w_reject;
  logic                w_any_coin;
  logic [1:0]          w_coin_cnt;
  logic [CREDIT_W:0]   w_value;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W:0]   w_diff;

  // Coin priority decode and credit arithmetic at CREDIT_W+1 bits
  always_comb begin
    w_coin_cnt = {1'b0, nickle} + {1'b0, dime} + {1'b0, quarter};
    w_any_coin = nickle | dime | quarter;
    if (nickle) begin
      w_value = VAL_NICK;
    end else if (dime) begin
      w_value = VAL_DIME;
    end else if (quarter) begin
      w_value = VAL_QTR;
    end else begin
      w_value = {(CREDIT_W+1){1'b0}};
    end
    w_sum  = {1'b0, r_credit} + w_value;
    w_diff = w_sum - PRICE_EXT;
  end

  // Next-state, next-credit, sales counter and coin rejection
  always_comb begin
    w_next_state  = r_state;
    w_next_credit = r_credit;
    w_next_sales  = r_sales;
    w_reject      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_coin) begin
          // Only the highest-priority coin is taken; any others on this edge bounce.
          w_reject = (w_coin_cnt > 2'd1);
          if (w_sum >= PRICE_EXT) begin
            w_next_credit = w_diff[CREDIT_W-1:0];
            w_next_state  = ST_VEND;
            if (r_sales != CNT_MAX) begin
              w_next_sales = r_sales + CNT_ONE;
            end else begin
              w_next_sales = r_sales;
            end
          end else begin
            w_next_credit = w_sum[CREDIT_W-1:0];
          end
        end else if (cancel && (r_credit != CREDIT_ZERO)) begin
          w_next_state = ST_CHANGE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_VEND: begin
        w_reject = w_any_coin;
        if (r_credit != CREDIT_ZERO) begin
          w_next_state = ST_CHANGE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        w_reject = w_any_coin;
        if (r_credit <= CREDIT_ONE) begin
          w_next_state  = ST_IDLE;
          w_next_credit = CREDIT_ZERO;
        end else begin
          w_next_credit = r_credit - CREDIT_ONE;
        end
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_next_credit = CREDIT_ZERO;
      end
    endcase
  end

  // State, credit, counter and output registers; outputs decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_credit      <= CREDIT_ZERO;
      r_sales       <= {CNT_W{1'b0}};
      r_soda        <= 1'b0;
      r_change      <= 1'b0;
      r_busy        <= 1'b0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_credit      <= w_next_credit;
      r_sales       <= w_next_sales;
      r_soda        <= (w_next_state == ST_VEND);
      r_change      <= (w_next_state == ST_CHANGE);
      r_busy        <= (w_next_state != ST_IDLE);
      r_coin_reject <= w_reject;
    end
  end

  assign soda          = r_soda;
  assign change_nickel = r_change;
  assign busy          = r_busy;
  assign coin_reject   = r_coin_reject;
  assign credit        = r_credit;
  assign sales_count   = r_sales;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench for vending_machine_param: an edge-level money model queues expected
// soda/change/reject pulses; a negedge monitor pops and compares them as the DUT shows them.
module tb_vending_machine_param;

  localparam int P     = 4;
  localparam int CW    = 4;
  localparam int CNTW  = 3;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tb_nickle = 1'b0, tb_dime = 1'b0, tb_quarter = 1'b0, tb_cancel = 1'b0;
  logic          soda, change_nickel, coin_reject, busy;
  logic [CW-1:0] credit;
  logic [CNTW-1:0] sales_count;

  vending_machine_param #(.PRICE_UNITS(P), .CREDIT_W(CW), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .nickle(tb_nickle), .dime(tb_dime), .quarter(tb_quarter), .cancel(tb_cancel),
    .soda(soda), .change_nickel(change_nickel), .coin_reject(coin_reject), .busy(busy),
    .credit(credit), .sales_count(sales_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int cr; int sc; } ev_t;
  ev_t q_soda[$];
  ev_t q_chg[$];
  int  q_rej[$];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int m_credit = 0;
  int m_sales = 0;
  int m_busy = 0;

  function automatic ev_t mk(input int c, input int cr, input int sc);
    ev_t e;
    e.cyc = c; e.cr = cr; e.sc = sc;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: money arithmetic per sampled edge; busy time = cycles of vend + change
  always @(posedge clk) begin : model
    int n, coins, val, sum, rem;
    n = cyc + 1;
    if (!rst_n) begin
      m_credit = 0; m_sales = 0; m_busy = 0;
    end else begin
      coins = int'(tb_nickle) + int'(tb_dime) + int'(tb_quarter);
      if (m_busy > 0) begin
        if (coins > 0) q_rej.push_back(n);
        m_busy--;
      end else begin
        if (coins > 1) q_rej.push_back(n);
        if (coins > 0) begin
          val = tb_nickle ? 1 : (tb_dime ? 2 : 5);
          sum = m_credit + val;
          if (sum >= P) begin
            rem = sum - P;
            if (m_sales < MAXC) m_sales++;
            q_soda.push_back(mk(n, rem, m_sales));
            for (int k = 1; k <= rem; k++) q_chg.push_back(mk(n + k, rem - k + 1, m_sales));
            m_busy = 1 + rem;
            m_credit = 0;
          end else begin
            m_credit = sum;
          end
        end else if (tb_cancel && m_credit > 0) begin
          for (int k = 0; k < m_credit; k++) q_chg.push_back(mk(n + k, m_credit - k, m_sales));
          m_busy = m_credit;
          m_credit = 0;
        end
      end
    end
  end

  // Monitor: pop expected events when the DUT pulses; flag events that came due unseen
  always @(negedge clk) begin : monitor
    ev_t e;
    int  rc;
    if (rst_n) begin
      if (soda) begin
        chk("soda_expected", int'(q_soda.size() > 0), 1);
        if (q_soda.size() > 0) begin
          e = q_soda.pop_front();
          chk("soda_cycle", cyc, e.cyc);
          chk("soda_credit", int'(credit), e.cr);
        end
      end else if (q_soda.size() > 0 && q_soda[0].cyc <= cyc) begin
        e = q_soda.pop_front();
        chk("soda_missing", int'(soda), 1);
      end
      if (change_nickel) begin
        chk("change_expected", int'(q_chg.size() > 0), 1);
        if (q_chg.size() > 0) begin
          e = q_chg.pop_front();
          chk("change_cycle", cyc, e.cyc);
          chk("change_credit", int'(credit), e.cr);
        end
      end else if (q_chg.size() > 0 && q_chg[0].cyc <= cyc) begin
        e = q_chg.pop_front();
        chk("change_missing", int'(change_nickel), 1);
      end
      if (coin_reject) begin
        chk("reject_expected", int'(q_rej.size() > 0), 1);
        if (q_rej.size() > 0) begin
          rc = q_rej.pop_front();
          chk("reject_cycle", cyc, rc);
        end
      end else if (q_rej.size() > 0 && q_rej[0] <= cyc) begin
        rc = q_rej.pop_front();
        chk("reject_missing", int'(coin_reject), 1);
      end
      chk("busy", int'(busy), int'(m_busy > 0));
      chk("sales_count", int'(sales_count), m_sales);
      if (m_busy == 0) chk("idle_credit", int'(credit), m_credit);
    end
  end

  task automatic step(input logic n, input logic d, input logic q, input logic c);
    @(negedge clk);
    tb_nickle = n; tb_dime = d; tb_quarter = q; tb_cancel = c;
  endtask

  task automatic settle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_busy == 0) done = 1'b1;
    end
    chk("settle_in_time", int'(done), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_soda", int'(soda), 0);
    chk("rst_change", int'(change_nickel), 0);
    chk("rst_reject", int'(coin_reject), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_credit", int'(credit), 0);
    chk("rst_sales", int'(sales_count), 0);
    rst_n = 1'b1;

    // Four nickels: exact price, no change
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("four_nickels_sales", int'(sales_count), 1);
    chk("four_nickels_credit", int'(credit), 0);

    // Quarter: one nickel change
    step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("quarter_busy_done", int'(busy), 0);

    // Dime, nickel, quarter: four nickels change
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    chk("dnq_credit", int'(credit), 0);

    // Dime, nickel, cancel: three-nickel refund, no sale
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("cancel_sales_unchanged", int'(sales_count), 3);

    // Nickel+dime together, then a quarter sale with a quarter injected during change
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("dual_coin_credit", int'(credit), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    settle();

    // Reset during the 2nd change cycle of a four-nickel payout
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_reset_change", int'(change_nickel), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_change", int'(change_nickel), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_credit", int'(credit), 0);
    chk("async_rst_sales", int'(sales_count), 0);
    q_soda.delete(); q_chg.delete(); q_rej.delete();
    m_credit = 0; m_sales = 0; m_busy = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_credit", int'(credit), 0);
    chk("post_rst_sales", int'(sales_count), 0);

    // Random traffic, long enough to saturate the sales counter
    for (int i = 0; i < 1500; i++) begin
      step(logic'($urandom_range(0, 99) < 25), logic'($urandom_range(0, 99) < 25),
           logic'($urandom_range(0, 99) < 20), logic'($urandom_range(0, 99) < 12));
    end
    settle();
    chk("sales_saturated", int'(sales_count), MAXC);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("queues_drained", q_soda.size() + q_chg.size() + q_rej.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor to the fixed-price soda controller. It accumulates nickel, dime and quarter credit toward a configurable price, vends, then returns change serially as one nickel pulse per cycle. It adds a cancel/refund path, coin rejection while busy, and a saturating sales counter. It sits between the coin-acceptor front end and the dispense/change actuators.

Parameters:
PRICE_UNITS, 4, price in nickel units (4 = 20 cents); legal range 1..(2**CREDIT_W - 5)
CREDIT_W, 4, width of the credit/remainder register; must satisfy 2**CREDIT_W > PRICE_UNITS + 4
CNT_W, 8, width of the saturating sales counter

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  asynchronous, active-low reset
nickle  in  1  coin sampled on clk edge; value 1 unit
dime  in  1  coin sampled on clk edge; value 2 units
quarter  in  1  coin sampled on clk edge; value 5 units
cancel  in  1  refund request, sampled on clk edge
soda  out  1  dispense pulse; high for exactly one cycle per sale
change_nickel  out  1  high one cycle per nickel of change or refund returned
coin_reject  out  1  registered pulse, one cycle after a coin was sampled and not accepted
busy  out  1  high whenever state is not IDLE
credit  out  CREDIT_W  current credit in IDLE; remaining change in VEND/CHANGE
sales_count  out  CNT_W  completed sales, saturating at all-ones

Behaviour:
- Reset (async assert, sync release is not required): state=IDLE, credit=0, sales_count=0. All outputs low or zero.
- Outputs are Moore/registered: soda=(state==VEND), change_nickel=(state==CHANGE), busy=(state!=IDLE).
- States: IDLE, VEND, CHANGE.
- IDLE, coin selection:
  - Priority is nickle > dime > quarter. Exactly one coin is accepted per edge.
  - Any other asserted coin in the same edge is rejected, and coin_reject pulses the next cycle.
- IDLE, credit update: sum = credit + value, computed at CREDIT_W+1 bits.
  - sum >= PRICE_UNITS: credit <= sum - PRICE_UNITS, state <= VEND, sales_count += 1 (saturating).
  - Otherwise: credit <= sum, state stays IDLE.
- IDLE, cancel with no coin:
  - credit>0: state <= CHANGE. Credit is refunded through CHANGE; no soda and no sales_count change.
  - credit==0: cancel is ignored.
- IDLE, cancel and coin in the same edge: the coin is processed and cancel is ignored.
- VEND (1 cycle): soda=1.
  - Next edge: credit>0 goes to CHANGE; otherwise IDLE.
- CHANGE: change_nickel=1 each cycle.
  - Each edge: credit <= credit-1.
  - When credit reaches 1 at an edge, the next state is IDLE with credit=0.
  - change_nickel is therefore high for exactly the number of cycles equal to the remainder.
- Latency:
  - Soda is high in the cycle after the edge that samples the completing coin.
  - The first change pulse is in the cycle after VEND.
- Busy-state inputs: any coin sampled in VEND or CHANGE is rejected (coin_reject pulse next cycle) and credit is unaffected. cancel is ignored.
- Width rule: the maximum credit is PRICE_UNITS-1+5. The parameter constraint guarantees no overflow. Credit in IDLE never reaches PRICE_UNITS.
- Reset mid-VEND/CHANGE: immediate return to IDLE, remaining change is discarded, and outputs drop asynchronously.
- sales_count at all-ones stays at all-ones on further sales; vending is otherwise unaffected.

Test Plan:
- PRICE_UNITS=4: four single-cycle nickle pulses -> soda high for 1 cycle after the 4th, zero change_nickel pulses, sales_count=1, credit=0.
- From reset, one quarter -> VEND (soda=1, credit=1), then 1 cycle of change_nickel, then IDLE with busy=0.
- dime, nickle, then quarter (sum 8) -> soda once, then 4 consecutive change_nickel cycles, then credit=0.
- dime + nickle (credit=3), then cancel -> 3 change_nickel cycles, soda never high, sales_count unchanged.
- nickle and dime asserted together in IDLE -> credit=1, coin_reject high 1 cycle; a quarter during CHANGE -> coin_reject pulse, change pulse count unchanged.
- rst_n low during the 2nd change cycle of a 4-nickel refund -> outputs 0 immediately; after release, state IDLE, credit=0, sales_count=0.
